// File: rtl/mipi_csi_rx_packet_parser_8b2lane.sv
// Two-lane CSI-2 packet parser: sync detect, header capture, payload framing with
// per-byte keep/last, and protocol error pulses. All outputs are registered.
module mipi_csi_rx_packet_parser_8b2lane #(
  parameter logic [15:0] SYNC_WORD   = 16'hB8B8,
  parameter logic [5:0]  LONG_DT_MIN = 6'h10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        lane_valid_i,
  input  logic [15:0] lane_byte_i,
  output logic        header_valid_o,
  output logic [5:0]  data_type_o,
  output logic [1:0]  vc_o,
  output logic [15:0] word_count_o,
  output logic [7:0]  ecc_o,
  output logic        payload_valid_o,
  output logic [15:0] payload_o,
  output logic [1:0]  payload_keep_o,
  output logic        payload_last_o,
  output logic        error_o
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAYLOAD, WAIT_END} state_t;

  state_t      state;
  logic        armed;
  logic [7:0]  di;
  logic [7:0]  wc_l;
  logic [15:0] cnt;
  logic [15:0] wc_full;

  assign wc_full = {lane_byte_i[7:0], wc_l};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state           <= IDLE;
      armed           <= 1'b0;
      di              <= '0;
      wc_l            <= '0;
      cnt             <= '0;
      header_valid_o  <= 1'b0;
      data_type_o     <= '0;
      vc_o            <= '0;
      word_count_o    <= '0;
      ecc_o           <= '0;
      payload_valid_o <= 1'b0;
      payload_o       <= '0;
      payload_keep_o  <= '0;
      payload_last_o  <= 1'b0;
      error_o         <= 1'b0;
    end else begin
      header_valid_o  <= 1'b0;
      payload_valid_o <= 1'b0;
      payload_o       <= '0;
      payload_keep_o  <= '0;
      payload_last_o  <= 1'b0;
      error_o         <= 1'b0;
      // A packet cut short by reset is skipped until the lanes go idle once.
      if (!lane_valid_i) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (lane_valid_i && armed) begin
            if (lane_byte_i == SYNC_WORD) begin
              state <= HDR0;
            end else begin
              error_o <= 1'b1;
              state   <= WAIT_END;
            end
          end
        end
        HDR0: begin
          if (!lane_valid_i) begin
            error_o <= 1'b1;
            state   <= IDLE;
          end else begin
            di    <= lane_byte_i[7:0];
            wc_l  <= lane_byte_i[15:8];
            state <= HDR1;
          end
        end
        HDR1: begin
          if (!lane_valid_i) begin
            error_o <= 1'b1;
            state   <= IDLE;
          end else begin
            header_valid_o <= 1'b1;
            data_type_o    <= di[5:0];
            vc_o           <= di[7:6];
            word_count_o   <= wc_full;
            ecc_o          <= lane_byte_i[15:8];
            cnt            <= wc_full;
            if (di[5:0] < LONG_DT_MIN || wc_full == 16'd0) state <= WAIT_END;
            else                                            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!lane_valid_i) begin
            error_o <= 1'b1;
            state   <= IDLE;
          end else begin
            payload_valid_o <= 1'b1;
            if (cnt == 16'd1) begin
              payload_o      <= {8'h00, lane_byte_i[7:0]};
              payload_keep_o <= 2'b01;
            end else begin
              payload_o      <= lane_byte_i;
              payload_keep_o <= 2'b11;
            end
            // Saturating countdown: an odd count ends on 1, never wraps.
            if (cnt <= 16'd2) begin
              payload_last_o <= 1'b1;
              cnt            <= '0;
              state          <= WAIT_END;
            end else begin
              cnt <= cnt - 16'd2;
            end
          end
        end
        WAIT_END: begin
          if (!lane_valid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_csi_rx_packet_parser_8b2lane.sv
// Scoreboard bench: expected header/payload/error events are queued as stimulus is
// driven and popped as the parser emits them.
module tb_mipi_csi_rx_packet_parser_8b2lane;

  localparam int K_HDR = 0;
  localparam int K_PAY = 1;
  localparam int K_ERR = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        lane_valid;
  logic [15:0] lane_byte;
  logic        header_valid;
  logic [5:0]  data_type;
  logic [1:0]  vc;
  logic [15:0] word_count;
  logic [7:0]  ecc;
  logic        payload_valid;
  logic [15:0] payload;
  logic [1:0]  payload_keep;
  logic        payload_last;
  logic        error;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } ev_t;

  ev_t q[$];
  int  n_chk = 0;
  int  n_err = 0;

  mipi_csi_rx_packet_parser_8b2lane dut (
    .clk_i(clk), .reset_i(reset), .lane_valid_i(lane_valid), .lane_byte_i(lane_byte),
    .header_valid_o(header_valid), .data_type_o(data_type), .vc_o(vc),
    .word_count_o(word_count), .ecc_o(ecc), .payload_valid_o(payload_valid),
    .payload_o(payload), .payload_keep_o(payload_keep), .payload_last_o(payload_last),
    .error_o(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pop_cmp(input int kind, input logic [31:0] val, input string tag);
    ev_t e;
    if (q.size() == 0) begin
      chk({"spurious_", tag}, 64'(val), 64'hFFFF_FFFF_FFFF_FFFF);
    end else begin
      e = q.pop_front();
      chk({tag, "_kind"}, 64'(kind), 64'(e.kind));
      chk(tag, 64'(val), 64'(e.val));
    end
  endtask

  function automatic ev_t hdr_ev(logic [1:0] v, logic [5:0] dt, logic [15:0] wc, logic [7:0] e);
    ev_t r;
    r.kind = K_HDR;
    r.val  = {dt, v, wc, e};
    return r;
  endfunction

  function automatic ev_t pay_ev(logic [15:0] d, logic [1:0] k, logic l);
    ev_t r;
    r.kind = K_PAY;
    r.val  = {13'd0, d, k, l};
    return r;
  endfunction

  function automatic ev_t err_ev();
    ev_t r;
    r.kind = K_ERR;
    r.val  = 32'd1;
    return r;
  endfunction

  always @(negedge clk) begin
    if (header_valid || payload_valid || error) begin
      if (header_valid && error) chk("hdr_err_same_cycle", 64'd1, 64'd0);
      if (header_valid) pop_cmp(K_HDR, {data_type, vc, word_count, ecc}, "header");
      if (payload_valid) pop_cmp(K_PAY, {13'd0, payload, payload_keep, payload_last}, "payload");
      if (error) pop_cmp(K_ERR, 32'd1, "error");
    end else if (payload_keep != 2'b00 || payload_last || payload != 16'h0) begin
      chk("idle_payload_outs", {45'd0, payload, payload_keep, payload_last}, 64'd0);
    end
  end

  task automatic drive(input logic v, input logic [15:0] w);
    lane_valid = v;
    lane_byte  = w;
    @(posedge clk);
    #1;
  endtask

  // Full packet with random payload; trunc>=0 drops valid after that many payload words.
  task automatic long_pkt(input logic [1:0] v, input logic [5:0] dt, input logic [15:0] wc,
                          input int trunc);
    logic [7:0]  e;
    logic [15:0] w;
    int          nw;
    bit          odd;
    e = 8'($urandom);
    q.push_back(hdr_ev(v, dt, wc, e));
    drive(1'b1, 16'hB8B8);
    drive(1'b1, {wc[7:0], v, dt});
    drive(1'b1, {e, wc[15:8]});
    if (dt >= 6'h10 && wc != 16'd0) begin
      nw = (int'(wc) + 1) / 2;
      for (int i = 0; i < nw; i++) begin
        if (trunc >= 0 && i == trunc) begin
          q.push_back(err_ev());
          drive(1'b0, 16'h0);
          return;
        end
        w   = 16'($urandom);
        odd = (i == nw - 1) && wc[0];
        q.push_back(pay_ev(odd ? {8'h00, w[7:0]} : w, odd ? 2'b01 : 2'b11, i == nw - 1));
        drive(1'b1, w);
      end
      drive(1'b1, 16'($urandom));
    end
    drive(1'b0, 16'h0);
  endtask

  initial begin
    reset      = 1'b1;
    lane_valid = 1'b0;
    lane_byte  = 16'h0;
    drive(1'b0, 16'h0);
    drive(1'b0, 16'h0);
    chk("reset_outs", {10'd0, header_valid, data_type, vc, word_count, ecc, payload_valid,
                       payload, payload_keep, payload_last, error}, 64'd0);
    reset = 1'b0;
    drive(1'b0, 16'h0);

    // Reference long packet with odd word count, CRC word then idle
    q.push_back(hdr_ev(2'd0, 6'h2B, 16'h0005, 8'h12));
    q.push_back(pay_ev(16'h2211, 2'b11, 1'b0));
    q.push_back(pay_ev(16'h4433, 2'b11, 1'b0));
    q.push_back(pay_ev(16'h0055, 2'b01, 1'b1));
    drive(1'b1, 16'hB8B8); drive(1'b1, 16'h052B); drive(1'b1, 16'h1200);
    drive(1'b1, 16'h2211); drive(1'b1, 16'h4433); drive(1'b1, 16'hCC55);
    drive(1'b1, 16'hDDEE); drive(1'b0, 16'h0);

    // Short packet: header only
    q.push_back(hdr_ev(2'd0, 6'h00, 16'h0001, 8'h07));
    drive(1'b1, 16'hB8B8); drive(1'b1, 16'h0100); drive(1'b1, 16'h0700);
    drive(1'b0, 16'h0);

    // Bad sync, then a good packet
    q.push_back(err_ev());
    drive(1'b1, 16'h00B8); drive(1'b1, 16'h1234); drive(1'b0, 16'h0);
    long_pkt(2'd1, 6'h2B, 16'd4, -1);

    // Truncated payload, then recovery
    long_pkt(2'd0, 6'h24, 16'd8, 2);
    long_pkt(2'd2, 6'h12, 16'd3, -1);

    // Reset in the middle of a wc=0x10 payload
    q.push_back(hdr_ev(2'd0, 6'h2A, 16'h0010, 8'h33));
    drive(1'b1, 16'hB8B8); drive(1'b1, 16'h102A); drive(1'b1, 16'h3300);
    for (int i = 1; i <= 3; i++) begin
      q.push_back(pay_ev(16'h1000 + 16'(i), 2'b11, 1'b0));
      drive(1'b1, 16'h1000 + 16'(i));
    end
    reset = 1'b1;
    drive(1'b1, 16'h1004);
    chk("midpkt_reset_outs", {10'd0, header_valid, data_type, vc, word_count, ecc,
                              payload_valid, payload, payload_keep, payload_last, error}, 64'd0);
    reset = 1'b0;
    for (int i = 5; i <= 8; i++) drive(1'b1, 16'h1000 + 16'(i));
    drive(1'b1, 16'hB8B8);
    drive(1'b1, 16'h5A5A);
    drive(1'b0, 16'h0);
    long_pkt(2'd3, 6'h1E, 16'd7, -1);

    // Back-to-back packets, zero-length long packet, maximum word count
    long_pkt(2'd0, 6'h2C, 16'd6, -1);
    long_pkt(2'd1, 6'h2D, 16'd9, -1);
    long_pkt(2'd0, 6'h20, 16'd0, -1);
    long_pkt(2'd0, 6'h10, 16'd2, -1);
    long_pkt(2'd0, 6'h0F, 16'd40, -1);
    long_pkt(2'd2, 6'h3F, 16'hFFFF, -1);

    drive(1'b0, 16'h0);
    drive(1'b0, 16'h0);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mipi_csi_rx_packet_parser_8b2lane.md
MIPI_CSI_RX_PACKET_PARSER_8B2LANE -- requirements
Module: mipi_csi_rx_packet_parser_8b2lane

Interface
REQ-001 Parameter: SYNC_WORD, default 16'hB8B8, sync byte pair expected on both lanes as the first valid word.
REQ-002 Parameter: LONG_DT_MIN, default 6'h10; data types at or above this value are long packets, data types below it are short packets.
REQ-003 clk_i  input  1  single clock; all logic rises on this edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 lane_valid_i  input  1  aligned-lane data valid, driven by the upstream lane aligner.
REQ-006 lane_byte_i  input  16  aligned bytes; [7:0] is lane 0 (even packet bytes), [15:8] is lane 1 (odd packet bytes).
REQ-007 header_valid_o  output  1  one-cycle pulse; the header fields below are valid in that cycle.
REQ-008 data_type_o  output  6  DI[5:0].
REQ-009 vc_o  output  2  DI[7:6].
REQ-010 word_count_o  output  16  {WC_H, WC_L}.
REQ-011 ecc_o  output  8  captured header ECC byte; not checked.
REQ-012 payload_valid_o  output  1  payload word valid.
REQ-013 payload_o  output  16  payload bytes, same byte ordering as lane_byte_i; invalid bytes are driven to 0.
REQ-014 payload_keep_o  output  2  per-byte valid; bit0 is [7:0].
REQ-015 payload_last_o  output  1  marks the final payload word.
REQ-016 error_o  output  1  one-cycle pulse on a protocol error.

Function
REQ-017 States SHALL be IDLE, HDR0, HDR1, PAYLOAD and WAIT_END.
REQ-018 IDLE: on lane_valid_i=1 with lane_byte_i==SYNC_WORD, the block SHALL go to HDR0; on lane_valid_i=1 with any other value, it SHALL pulse error_o and go to WAIT_END.
REQ-019 HDR0 SHALL latch DI=[7:0] and WC_L=[15:8], then go to HDR1.
REQ-020 HDR1 SHALL latch WC_H=[7:0] and ECC=[15:8] and SHALL pulse header_valid_o on the next cycle with all header fields.
REQ-021 From HDR1, the next state SHALL be:
  - WAIT_END if DT<LONG_DT_MIN;
  - WAIT_END if WC==0;
  - PAYLOAD otherwise.
REQ-022 PAYLOAD SHALL load a 16-bit remaining-byte counter with WC, and SHALL decrement it by 2 per valid word, saturating at 0.
REQ-023 Each PAYLOAD word SHALL be registered to payload_o with one-cycle latency.
REQ-024 payload_keep_o SHALL be 2'b11 except on the final word of an odd WC, where it SHALL be 2'b01 and [15:8] SHALL be 0.
REQ-025 payload_last_o SHALL be asserted with the word that brings the counter to 0; the block SHALL then go to WAIT_END.
REQ-026 CRC bytes and any trailing bytes SHALL be discarded in WAIT_END.
REQ-027 WAIT_END SHALL go to IDLE on the first cycle with lane_valid_i=0.
REQ-028 If lane_valid_i drops in HDR0, HDR1 or PAYLOAD, the block SHALL pulse error_o on the next cycle, SHALL NOT assert payload_last_o, and SHALL go to IDLE.
REQ-029 In states other than PAYLOAD, payload_valid_o, payload_keep_o and payload_last_o SHALL be 0.
REQ-030 header_valid_o and error_o SHALL never assert in the same cycle.
REQ-031 WC=16'hFFFF SHALL be handled: the counter SHALL NOT wrap, and the last word SHALL have keep 2'b01.

Reset
REQ-032 reset_i=1 SHALL force state IDLE, clear the counter and drive every output to 0 at the next edge, including mid-packet.
REQ-033 After reset, any packet in progress SHALL be ignored until lane_valid_i has been 0 for at least one cycle and a new SYNC_WORD arrives.

Verification
REQ-034 Long packet: valid words B8B8, 052B, 1200, 2211, 4433, CC55, DDEE, then valid low. Required response:
  - header_valid_o pulse with dt=2B, vc=0, wc=0005, ecc=12;
  - payload 2211/11, 4433/11, 0055/01 with last on the third word;
  - CRC ignored, no error_o.
REQ-035 Short packet: words B8B8, 0100, 0700, then valid low. Required response: header pulse with dt=00, wc=0001, ecc=07; no payload_valid_o.
REQ-036 Bad sync: first valid word 00B8. Required response: error_o pulse, no header pulse; the next correct packet parses normally.
REQ-037 Truncation: long packet with wc=0008 where valid drops after 2 payload words. Required response: 2 payload words without last, then error_o pulse, state IDLE.
REQ-038 Reset: reset_i asserted during the payload of a wc=0010 packet. Required response:
  - all outputs 0 next cycle;
  - remaining words of that packet produce no output;
  - a following packet parses correctly.
REQ-039 Back-to-back: two long packets separated by one invalid cycle. Required response: both headers and payloads are delivered, and last asserts once per packet.
